// File: rtl/softcore_multitimer.sv
// Multi-channel down-counting timer behind a simple word-addressed register slave.
// Define SOFTCORE_MULTITIMER_SNAPSHOT_EN to give each channel a captured SNAP register.
module softcore_multitimer #(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h0007A11F
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(NUM_CH)+1:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [NUM_CH-1:0]         irq_vec,
  output logic                      irq
);

  localparam int             CH_W    = $clog2(NUM_CH);
  localparam int             AW      = CH_W + 2;
  localparam logic [CNT_W-1:0] RST_CNT = RESET_PERIOD[CNT_W-1:0];
  localparam logic [1:0]     REG_STATUS  = 2'd0;
  localparam logic [1:0]     REG_CONTROL = 2'd1;
  localparam logic [1:0]     REG_PERIOD  = 2'd2;
  localparam logic [1:0]     REG_SNAP    = 2'd3;

  logic [CH_W:0] w_ch;
  logic [1:0]    w_reg;
  logic          w_wr;
  logic [31:0]   w_rd;
  logic [31:0]   w_rd_ch [NUM_CH];
  logic [31:0]   r_readdata;
  logic          w_unused;

  assign w_reg    = address[1:0];
  assign w_wr     = chipselect & ~write_n;
  assign w_unused = &{1'b0, writedata};

  // Extra top bit keeps the channel index well-formed when NUM_CH is 1.
  generate
    if (CH_W == 0) begin : g_one_ch
      assign w_ch = '0;
    end else begin : g_many_ch
      assign w_ch = {1'b0, address[AW-1:2]};
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_period;
      logic             r_run;
      logic             r_to;
      logic             r_ito;
      logic             r_cont;
      logic             r_at_zero;
      logic             w_sel;
      logic             w_evt;
      logic [CNT_W-1:0] w_snap;

      assign w_sel = w_wr && (int'(w_ch) == gi);
      // r_at_zero remembers a running counter already sat at 0, so PERIOD=0 fires once.
      assign w_evt = r_run && (r_cnt == '0) && !r_at_zero;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt     <= RST_CNT;
          r_period  <= RST_CNT;
          r_run     <= 1'b0;
          r_to      <= 1'b0;
          r_ito     <= 1'b0;
          r_cont    <= 1'b0;
          r_at_zero <= 1'b0;
        end else begin
          r_at_zero <= r_run && (r_cnt == '0);
          if (w_evt)
            r_to <= 1'b1;
          else if (w_sel && w_reg == REG_STATUS)
            r_to <= 1'b0;
          if (r_run) begin
            if (r_cnt == '0) begin
              r_cnt <= r_period;
              if (!r_cont)
                r_run <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          if (w_sel && w_reg == REG_CONTROL) begin
            r_ito  <= writedata[0];
            r_cont <= writedata[1];
            if (writedata[2])
              r_run <= 1'b1;
            else if (writedata[3])
              r_run <= 1'b0;
          end
          if (w_sel && w_reg == REG_PERIOD) begin
            r_period <= writedata[CNT_W-1:0];
            r_cnt    <= writedata[CNT_W-1:0];
            r_run    <= 1'b0;
          end
        end
      end

`ifdef SOFTCORE_MULTITIMER_SNAPSHOT_EN
      logic [CNT_W-1:0] r_snap;
      always_ff @(posedge clk) begin
        if (reset)
          r_snap <= '0;
        else if (w_sel && w_reg == REG_SNAP)
          r_snap <= r_cnt;
      end
      assign w_snap = r_snap;
`else
      assign w_snap = r_cnt;
`endif

      assign w_rd_ch[gi] = (w_reg == REG_STATUS)  ? {30'd0, r_run, r_to}   :
                           (w_reg == REG_CONTROL) ? {30'd0, r_cont, r_ito} :
                           (w_reg == REG_PERIOD)  ? 32'(r_period)          :
                                                    32'(w_snap);
      assign irq_vec[gi] = r_to & r_ito;
    end
  endgenerate

  // Channel indices past NUM_CH fall through to zero.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (int'(w_ch) == i)
        w_rd = w_rd_ch[i];
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_readdata <= '0;
    else
      r_readdata <= w_rd;
  end

  assign readdata = r_readdata;
  assign irq      = |irq_vec;

endmodule

// File: doc/softcore_multitimer.md
SOFTCORE_MULTITIMER -- requirements
Module: softcore_multitimer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter and period width in bits (8..32).
REQ-003 SHALL have parameter RESET_PERIOD, default 32'h0007A11F, period and counter value at reset, truncated to CNT_W.
REQ-004 SHALL have port clk, input, 1, sole clock; one clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1, reset; reset is synchronous and active-high.
REQ-006 SHALL have port address, input, $clog2(NUM_CH)+2, word address: bits [top:2] = channel, bits [1:0] = register.
REQ-007 SHALL have port chipselect, input, 1, slave select.
REQ-008 SHALL have port write_n, input, 1, active-low write strobe, qualified by chipselect.
REQ-009 SHALL have port writedata, input, 32, write data.
REQ-010 SHALL have port readdata, output, 32, registered read data.
REQ-011 SHALL have port irq_vec, output, NUM_CH, per-channel interrupt.
REQ-012 SHALL have port irq, output, 1, OR of irq_vec.

Function
REQ-013 Register map per channel SHALL be:
- 0 STATUS: bit0 TO, bit1 RUN; any write clears TO.
- 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP; bits [1:0] stored, bits [3:2] strobes that read back as 0.
- 2 PERIOD: CNT_W bits.
- 3 SNAP.
- Unused read bits SHALL be 0. A channel index >= NUM_CH SHALL read 0 and ignore writes.
REQ-014 Read latency SHALL be one cycle: readdata is updated every cycle from the current address, regardless of chipselect.
REQ-015 A running channel SHALL decrement by 1 per cycle; at count 0 it SHALL reload PERIOD on the next cycle.
REQ-016 A timeout event SHALL occur on the cycle the counter first equals 0 (rising detect); TO SHALL be set the following cycle.
REQ-017 At count 0 with CONT=0, RUN SHALL clear; the counter holds at PERIOD after the reload.
REQ-018 A PERIOD write SHALL load the counter with the new value the next cycle and clear RUN.
REQ-019 START and STOP written together SHALL start (START has priority); START while running SHALL not reload the counter.
REQ-020 A STATUS write coinciding with a timeout event SHALL leave TO=1 (the set wins).
REQ-021 irq_vec[n] SHALL equal TO[n] AND ITO[n], combinationally from registers.
REQ-022 Channels SHALL be fully independent; an access to channel n SHALL not alter the state of any other channel.
REQ-023 PERIOD=0 in CONT mode SHALL produce a counter fixed at 0; TO SHALL be set once, not every cycle.

Reset
REQ-024 While reset=1 at a clk edge, every channel SHALL be set to:
- counter = PERIOD = RESET_PERIOD
- RUN = 0, TO = 0, ITO = 0, CONT = 0, SNAP = 0
- readdata = 0, irq_vec = 0, irq = 0
REQ-025 Reset mid-count SHALL abort the count immediately with no timeout event; reset SHALL take priority over any simultaneous bus write.

Configuration
REQ-026 With SOFTCORE_MULTITIMER_SNAPSHOT_EN defined, a write to SNAP SHALL capture the live counter into SNAP the next cycle, and reads of SNAP SHALL return the captured value.
REQ-027 Without SOFTCORE_MULTITIMER_SNAPSHOT_EN, reads of SNAP SHALL return the live counter, SNAP writes SHALL be ignored, and no snapshot storage SHALL be built.

Verification
REQ-028 Reset, then read ch0 PERIOD -> 0x0007A11F; ch0 STATUS -> 0; irq=0.
REQ-029 ch1: PERIOD=5, CONTROL=0x7 (START|CONT|ITO) -> counter runs 5,4,3,2,1,0, reloads; TO and irq_vec[1] rise one cycle after the counter reaches 0 and repeat every 6 cycles; irq_vec[0]=0 throughout.
REQ-030 ch0: PERIOD=3, CONTROL=0x4 (one-shot) -> RUN clears at count 0, TO=1, irq=0 because ITO=0.
REQ-031 STATUS write on the same cycle as a timeout event -> TO reads 1; a later STATUS write -> TO reads 0.
REQ-032 CONTROL=0xC (START|STOP) -> RUN=1; PERIOD write while running -> RUN=0 and the counter equals the new PERIOD one cycle later.
REQ-033 With SOFTCORE_MULTITIMER_SNAPSHOT_EN defined: PERIOD=100, start, write SNAP after 10 cycles -> SNAP reads the counter value at the write cycle and stays constant. Without the macro: SNAP reads the live counter and changes on consecutive reads.
